// File: rtl/page_column_parser.sv
// Walks a linked chain of table pages and splits each row word into NUM_COLS lanes of a shared column FIFO.
// Define PARSER_STATS_EN to add the pages_scanned / stall_cycles counters.
module page_column_parser #(
    parameter int NUM_COLS      = 8,
    parameter int COL_W         = 32,
    parameter int ROWS_PER_PAGE = 127,
    parameter int FIFO_DEPTH    = 16,
    parameter int ADDR_W        = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [ADDR_W-1:0]           target_page_addr,
    input  logic [31:0]                 record_num,
    input  logic [ADDR_W-1:0]           read_page_addr,
    output logic                        page_hit,
    input  logic [NUM_COLS*COL_W-1:0]   data_in,
    input  logic                        data_valid,
    output logic                        data_rd,
    output logic [ADDR_W-1:0]           read_page_cmd,
    output logic                        read_page_cmd_en,
    input  logic                        col_rd_en,
    output logic [NUM_COLS*COL_W-1:0]   col_dout,
    output logic                        col_empty,
    output logic [$clog2(FIFO_DEPTH):0] col_level,
    output logic                        busy,
    output logic                        table_scan_done
`ifdef PARSER_STATS_EN
    ,
    output logic [15:0]                 pages_scanned,
    output logic [31:0]                 stall_cycles
`endif
);

    localparam int ROW_W = NUM_COLS * COL_W;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int WC_W  = $clog2(ROWS_PER_PAGE + 1);
    localparam logic [WC_W-1:0]  WORDS_LAST = WC_W'(ROWS_PER_PAGE);
    localparam logic [31:0]      RPP32      = 32'(ROWS_PER_PAGE);
    localparam logic [LVL_W-1:0] LVL_FULL   = LVL_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_PAGE,
        S_HEADER,
        S_ROWS,
        S_TAIL,
        S_DONE
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] expAddr_q;
    logic [ADDR_W-1:0] cmdAddr_q;
    logic [31:0]       recNum_q;
    logic [31:0]       rowCnt_q;
    logic [WC_W-1:0]   wordCnt_q;
    logic              pageHit_q;
    logic              scanDone_q;

    logic [ROW_W-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wrPtr_q;
    logic [PTR_W-1:0]  rdPtr_q;
    logic [LVL_W-1:0]  level_q;
    logic [LVL_W-1:0]  level_d;
    logic [ROW_W-1:0]  colDout_q;

    logic              fifoFull;
    logic              push;
    logic              pop;
    logic              hdrPop;
    logic              tailPop;
    logic              rowsLeft;
    logic              lastRow;
    logic              lastWord;
    logic [31:0]       rowCnt_d;
    logic [WC_W-1:0]   wordCnt_d;

    assign fifoFull  = (level_q == LVL_FULL);
    assign push      = (state_q == S_ROWS) && data_valid && !fifoFull;
    assign pop       = col_rd_en && (level_q != '0);
    assign hdrPop    = (state_q == S_HEADER) && data_valid;
    assign tailPop   = (state_q == S_TAIL) && data_valid;
    assign rowsLeft  = (recNum_q - rowCnt_q) > RPP32;
    assign rowCnt_d  = rowCnt_q + 32'd1;
    assign wordCnt_d = wordCnt_q + WC_W'(1);
    assign lastRow   = (rowCnt_d == recNum_q);
    assign lastWord  = (wordCnt_d == WORDS_LAST);

    // The next-page command rides out in the same cycle the header is popped.
    assign data_rd          = hdrPop || push || tailPop;
    assign read_page_cmd    = hdrPop ? data_in[ADDR_W-1:0] : cmdAddr_q;
    assign read_page_cmd_en = hdrPop && rowsLeft;
    assign page_hit         = pageHit_q;
    assign busy             = (state_q != S_IDLE) && (state_q != S_DONE);
    assign table_scan_done  = scanDone_q;
    assign col_dout         = colDout_q;
    assign col_empty        = (level_q == '0);
    assign col_level        = level_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            expAddr_q  <= '0;
            cmdAddr_q  <= '0;
            recNum_q   <= '0;
            rowCnt_q   <= '0;
            wordCnt_q  <= '0;
            pageHit_q  <= 1'b0;
            scanDone_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        recNum_q  <= record_num;
                        rowCnt_q  <= '0;
                        wordCnt_q <= '0;
                        if (record_num == 32'd0) begin
                            state_q    <= S_DONE;
                            scanDone_q <= 1'b1;
                        end else begin
                            state_q    <= S_WAIT_PAGE;
                            expAddr_q  <= target_page_addr;
                            scanDone_q <= 1'b0;
                        end
                    end
                end
                S_WAIT_PAGE: begin
                    if (read_page_addr == expAddr_q) begin
                        state_q   <= S_HEADER;
                        pageHit_q <= 1'b1;
                    end
                end
                S_HEADER: begin
                    if (data_valid) begin
                        expAddr_q <= data_in[ADDR_W-1:0];
                        cmdAddr_q <= data_in[ADDR_W-1:0];
                        wordCnt_q <= '0;
                        state_q   <= S_ROWS;
                    end
                end
                S_ROWS: begin
                    if (push) begin
                        rowCnt_q  <= rowCnt_d;
                        wordCnt_q <= wordCnt_d;
                        if (lastRow && lastWord) begin
                            state_q    <= S_DONE;
                            pageHit_q  <= 1'b0;
                            scanDone_q <= 1'b1;
                        end else if (lastRow) begin
                            state_q <= S_TAIL;
                        end else if (lastWord) begin
                            state_q   <= S_WAIT_PAGE;
                            pageHit_q <= 1'b0;
                        end
                    end
                end
                S_TAIL: begin
                    if (tailPop) begin
                        wordCnt_q <= wordCnt_d;
                        if (lastWord) begin
                            state_q    <= S_DONE;
                            pageHit_q  <= 1'b0;
                            scanDone_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // All lanes share one storage row, so a single pointer pair serves every column.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wrPtr_q] <= data_in;
        end
    end

    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !push) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            level_q   <= '0;
            colDout_q <= '0;
        end else begin
            if (push) begin
                wrPtr_q <= wrPtr_q + PTR_W'(1);
            end
            if (pop) begin
                colDout_q <= mem_q[rdPtr_q];
                rdPtr_q   <= rdPtr_q + PTR_W'(1);
            end
            level_q <= level_d;
        end
    end

`ifdef PARSER_STATS_EN
    logic [15:0] pagesScanned_q;
    logic [31:0] stallCycles_q;

    always_ff @(posedge clk) begin
        if (rst || (start && ((state_q == S_IDLE) || (state_q == S_DONE)))) begin
            pagesScanned_q <= '0;
            stallCycles_q  <= '0;
        end else begin
            if (hdrPop && (pagesScanned_q != 16'hFFFF)) begin
                pagesScanned_q <= pagesScanned_q + 16'd1;
            end
            if ((state_q == S_ROWS) && data_valid && fifoFull && (stallCycles_q != 32'hFFFF_FFFF)) begin
                stallCycles_q <= stallCycles_q + 32'd1;
            end
        end
    end

    assign pages_scanned = pagesScanned_q;
    assign stall_cycles  = stallCycles_q;
`endif

endmodule

// File: tb/tb_page_column_parser.sv
// Directed bench for page_column_parser: a queued page source feeds an 8x32 instance; a 3x16 instance checks lane order.
// PARSER_STATS_EN only adds port hookups here.
module tb_page_column_parser;

    localparam int NC    = 8;
    localparam int CW    = 32;
    localparam int RPP   = 4;
    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int ROW_W = NC * CW;

    typedef struct packed {
        logic [AW-1:0]    addr;
        logic [ROW_W-1:0] word;
    } srcEntry_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [AW-1:0]    target_page_addr;
    logic [31:0]      record_num;
    logic [AW-1:0]    read_page_addr;
    logic             page_hit;
    logic [ROW_W-1:0] data_in;
    logic             data_valid;
    logic             data_rd;
    logic [AW-1:0]    read_page_cmd;
    logic             read_page_cmd_en;
    logic             col_rd_en;
    logic [ROW_W-1:0] col_dout;
    logic             col_empty;
    logic [2:0]       col_level;
    logic             busy;
    logic             table_scan_done;

    logic             start2;
    logic [AW-1:0]    target2;
    logic [31:0]      recordNum2;
    logic [AW-1:0]    readPageAddr2;
    logic             pageHit2;
    logic [47:0]      dataIn2;
    logic             dataValid2;
    logic             dataRd2;
    logic [AW-1:0]    readPageCmd2;
    logic             readPageCmdEn2;
    logic             colRdEn2;
    logic [47:0]      colDout2;
    logic             colEmpty2;
    logic [2:0]       colLevel2;
    logic             busy2;
    logic             scanDone2;

`ifdef PARSER_STATS_EN
    logic [15:0] pagesScanned;
    logic [31:0] stallCycles;
    logic [15:0] pagesScanned2;
    logic [31:0] stallCycles2;
`endif

    srcEntry_t        srcQ[$];
    logic [ROW_W-1:0] obsRows[$];
    logic [AW-1:0]    obsCmds[$];
    bit               useOverride = 1'b0;
    logic [AW-1:0]    overrideAddr = '0;
    int               popCount = 0;
    int               checks = 0;
    int               errors = 0;

    page_column_parser #(
        .NUM_COLS(NC), .COL_W(CW), .ROWS_PER_PAGE(RPP), .FIFO_DEPTH(DEPTH), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .target_page_addr(target_page_addr),
        .record_num(record_num), .read_page_addr(read_page_addr), .page_hit(page_hit),
        .data_in(data_in), .data_valid(data_valid), .data_rd(data_rd),
        .read_page_cmd(read_page_cmd), .read_page_cmd_en(read_page_cmd_en),
        .col_rd_en(col_rd_en), .col_dout(col_dout), .col_empty(col_empty),
        .col_level(col_level), .busy(busy), .table_scan_done(table_scan_done)
`ifdef PARSER_STATS_EN
        , .pages_scanned(pagesScanned), .stall_cycles(stallCycles)
`endif
    );

    page_column_parser #(
        .NUM_COLS(3), .COL_W(16), .ROWS_PER_PAGE(RPP), .FIFO_DEPTH(DEPTH), .ADDR_W(AW)
    ) dutLanes (
        .clk(clk), .rst(rst), .start(start2), .target_page_addr(target2),
        .record_num(recordNum2), .read_page_addr(readPageAddr2), .page_hit(pageHit2),
        .data_in(dataIn2), .data_valid(dataValid2), .data_rd(dataRd2),
        .read_page_cmd(readPageCmd2), .read_page_cmd_en(readPageCmdEn2),
        .col_rd_en(colRdEn2), .col_dout(colDout2), .col_empty(colEmpty2),
        .col_level(colLevel2), .busy(busy2), .table_scan_done(scanDone2)
`ifdef PARSER_STATS_EN
        , .pages_scanned(pagesScanned2), .stall_cycles(stallCycles2)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [ROW_W-1:0] makeRow(input int r);
        logic [ROW_W-1:0] w;
        w = '0;
        for (int i = 0; i < NC; i++) begin
            w[i*CW +: CW] = 32'hC0DE_0000 + 32'(r * 16 + i);
        end
        return w;
    endfunction

    task automatic refreshSource();
        if (srcQ.size() > 0) begin
            data_valid     = 1'b1;
            data_in        = srcQ[0].word;
            read_page_addr = srcQ[0].addr;
        end else begin
            data_valid     = 1'b0;
            data_in        = '0;
            read_page_addr = 32'hFFFF_FFFF;
        end
        if (useOverride) begin
            read_page_addr = overrideAddr;
        end
    endtask

    task automatic loadPage(input logic [AW-1:0] addr, input logic [AW-1:0] nextAddr,
                            input int firstRow, input int nRows);
        srcEntry_t e;
        e.addr = addr;
        e.word = '0;
        e.word[ROW_W-1 -: 32] = 32'hFEED_FACE;
        e.word[AW-1:0] = nextAddr;
        srcQ.push_back(e);
        for (int w = 0; w < RPP; w++) begin
            e.word = (w < nRows) ? makeRow(firstRow + w) : {NC{32'hBAD0_0000 + 32'(w)}};
            srcQ.push_back(e);
        end
        refreshSource();
    endtask

    // Source pops on the edge where data_rd was high, then presents the next word just after the edge.
    initial begin : sourceModel
        bit popped;
        forever begin
            @(posedge clk);
            popped = data_rd;
            #1;
            if (popped && srcQ.size() > 0) begin
                srcQ.pop_front();
                popCount++;
            end
            refreshSource();
        end
    end

    task automatic pulseStart(input logic [AW-1:0] addr, input logic [31:0] rec);
        @(negedge clk);
        target_page_addr = addr;
        record_num       = rec;
        start            = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic applyStimulus(input int maxCycles, output bit timedOut);
        bit pending;
        obsRows.delete();
        obsCmds.delete();
        timedOut = 1'b1;
        pending  = col_rd_en && !col_empty;
        for (int c = 0; c < maxCycles; c++) begin
            @(negedge clk);
            if (pending) obsRows.push_back(col_dout);
            if (read_page_cmd_en) obsCmds.push_back(read_page_cmd);
            pending = col_rd_en && !col_empty;
            if (table_scan_done && col_empty && !pending) begin
                timedOut = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0 || page_hit !== 1'b0 || table_scan_done !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_flags: busy=%0b hit=%0b done=%0b, want 0 0 0", busy, page_hit, table_scan_done); end
        checks++; if (data_rd !== 1'b0 || read_page_cmd_en !== 1'b0 || read_page_cmd !== '0) begin
            errors++; $display("[TB] FAIL reset_cmd: rd=%0b en=%0b cmd=%h, want 0 0 0", data_rd, read_page_cmd_en, read_page_cmd); end
        checks++; if (col_empty !== 1'b1 || col_level !== 3'd0 || col_dout !== '0) begin
            errors++; $display("[TB] FAIL reset_fifo: empty=%0b level=%0d dout=%h, want 1 0 0", col_empty, col_level, col_dout); end
        rst = 1'b0;
    endtask

    task automatic test_zero_records();
        int popsBefore;
        srcQ.delete();
        loadPage(32'h4000, 32'h4100, 900, 4);
        popsBefore = popCount;
        pulseStart(32'h4000, 32'd0);
        checks++; if (table_scan_done !== 1'b1) begin
            errors++; $display("[TB] FAIL zero_done: got %0b expected 1", table_scan_done); end
        checks++; if (busy !== 1'b0 || data_rd !== 1'b0 || read_page_cmd_en !== 1'b0) begin
            errors++; $display("[TB] FAIL zero_idle: busy=%0b rd=%0b en=%0b, want 0 0 0", busy, data_rd, read_page_cmd_en); end
        @(negedge clk);
        checks++; if (popCount !== popsBefore) begin
            errors++; $display("[TB] FAIL zero_pops: got %0d pops expected %0d", popCount, popsBefore); end
        srcQ.delete();
        refreshSource();
    endtask

    task automatic test_full_scan();
        bit to;
        logic [AW-1:0]    expCmd;
        logic [AW-1:0]    gotCmd;
        logic [ROW_W-1:0] gotRow;
        loadPage(32'h100, 32'h200, 0, 4);
        loadPage(32'h200, 32'h300, 4, 4);
        loadPage(32'h300, 32'h999, 8, 2);
        col_rd_en = 1'b1;
        pulseStart(32'h100, 32'd10);
        applyStimulus(300, to);
        checks++; if (to !== 1'b0) begin
            errors++; $display("[TB] FAIL scan_timeout: timed out, rows=%0d expected 10", obsRows.size()); end
        checks++; if (obsCmds.size() !== 2) begin
            errors++; $display("[TB] FAIL scan_cmd_count: got %0d expected 2", obsCmds.size()); end
        for (int i = 0; i < 2; i++) begin
            expCmd = (i == 0) ? 32'h200 : 32'h300;
            gotCmd = (i < obsCmds.size()) ? obsCmds[i] : 'x;
            checks++; if (gotCmd !== expCmd) begin
                errors++; $display("[TB] FAIL scan_cmd%0d: got %h expected %h", i, gotCmd, expCmd); end
        end
        checks++; if (obsRows.size() !== 10) begin
            errors++; $display("[TB] FAIL scan_row_count: got %0d expected 10", obsRows.size()); end
        for (int i = 0; i < 10; i++) begin
            gotRow = (i < obsRows.size()) ? obsRows[i] : 'x;
            checks++; if (gotRow !== makeRow(i)) begin
                errors++; $display("[TB] FAIL scan_row%0d: got %h expected %h", i, gotRow, makeRow(i)); end
        end
        checks++; if (srcQ.size() !== 0) begin
            errors++; $display("[TB] FAIL scan_tail: %0d source words left, expected 0", srcQ.size()); end
        checks++; if (table_scan_done !== 1'b1 || busy !== 1'b0 || page_hit !== 1'b0) begin
            errors++; $display("[TB] FAIL scan_end: done=%0b busy=%0b hit=%0b, want 1 0 0", table_scan_done, busy, page_hit); end
    endtask

    task automatic test_fifo_full();
        bit to;
        logic [ROW_W-1:0] gotRow;
        loadPage(32'h1000, 32'h2000, 100, 4);
        loadPage(32'h2000, 32'h3000, 104, 2);
        col_rd_en = 1'b0;
        pulseStart(32'h1000, 32'd6);
        repeat (20) @(negedge clk);
        checks++; if (col_level !== 3'd4) begin
            errors++; $display("[TB] FAIL full_level: got %0d expected 4", col_level); end
        checks++; if (data_valid !== 1'b1 || data_rd !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("[TB] FAIL full_stall: valid=%0b rd=%0b busy=%0b, want 1 0 1", data_valid, data_rd, busy); end
        checks++; if (srcQ.size() !== 4) begin
            errors++; $display("[TB] FAIL full_words_left: got %0d expected 4", srcQ.size()); end
        col_rd_en = 1'b1;
        applyStimulus(200, to);
        checks++; if (to !== 1'b0 || obsRows.size() !== 6) begin
            errors++; $display("[TB] FAIL full_drain: timeout=%0b rows=%0d, want 0 6", to, obsRows.size()); end
        for (int i = 0; i < 6; i++) begin
            gotRow = (i < obsRows.size()) ? obsRows[i] : 'x;
            checks++; if (gotRow !== makeRow(100 + i)) begin
                errors++; $display("[TB] FAIL full_row%0d: got %h expected %h", i, gotRow, makeRow(100 + i)); end
        end
    endtask

    task automatic test_page_wait();
        bit to;
        int popsBefore;
        int hitErrs;
        useOverride  = 1'b1;
        overrideAddr = 32'h7777;
        loadPage(32'h5000, 32'h6000, 300, 4);
        col_rd_en = 1'b1;
        pulseStart(32'h5000, 32'd4);
        popsBefore = popCount;
        hitErrs = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (page_hit !== 1'b0) hitErrs++;
        end
        checks++; if (hitErrs !== 0) begin
            errors++; $display("[TB] FAIL wait_hit: page_hit high in %0d of 20 cycles, expected 0", hitErrs); end
        checks++; if (popCount !== popsBefore) begin
            errors++; $display("[TB] FAIL wait_pops: got %0d pops expected %0d", popCount, popsBefore); end
        useOverride = 1'b0;
        refreshSource();
        @(negedge clk);
        checks++; if (page_hit !== 1'b1) begin
            errors++; $display("[TB] FAIL wait_match_hit: got %0b expected 1", page_hit); end
        applyStimulus(100, to);
        checks++; if (to !== 1'b0 || obsRows.size() !== 4 || obsCmds.size() !== 0) begin
            errors++; $display("[TB] FAIL wait_scan: timeout=%0b rows=%0d cmds=%0d, want 0 4 0", to, obsRows.size(), obsCmds.size()); end
        checks++; if (obsRows.size() < 4 || obsRows[3] !== makeRow(303)) begin
            errors++; $display("[TB] FAIL wait_last_row: rows=%0d, expected last row %h", obsRows.size(), makeRow(303)); end
    endtask

    task automatic test_reset_mid_scan();
        bit to;
        bit reached;
        logic [ROW_W-1:0] gotRow;
        loadPage(32'h8000, 32'h9000, 400, 4);
        loadPage(32'h9000, 32'hA000, 404, 4);
        col_rd_en = 1'b0;
        pulseStart(32'h8000, 32'd8);
        reached = 1'b0;
        for (int c = 0; c < 40 && !reached; c++) begin
            @(negedge clk);
            if (col_level == 3'd2) reached = 1'b1;
        end
        checks++; if (reached !== 1'b1) begin
            errors++; $display("[TB] FAIL mid_reach: level %0d never reached 2", col_level); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || page_hit !== 1'b0 || data_rd !== 1'b0 || table_scan_done !== 1'b0) begin
            errors++; $display("[TB] FAIL mid_flags: busy=%0b hit=%0b rd=%0b done=%0b, want 0 0 0 0", busy, page_hit, data_rd, table_scan_done); end
        checks++; if (read_page_cmd !== '0 || read_page_cmd_en !== 1'b0) begin
            errors++; $display("[TB] FAIL mid_cmd: cmd=%h en=%0b, want 0 0", read_page_cmd, read_page_cmd_en); end
        checks++; if (col_empty !== 1'b1 || col_level !== 3'd0 || col_dout !== '0) begin
            errors++; $display("[TB] FAIL mid_fifo: empty=%0b level=%0d dout=%h, want 1 0 0", col_empty, col_level, col_dout); end
        rst = 1'b0;
        srcQ.delete();
        refreshSource();
        loadPage(32'hA000, 32'hB000, 200, 4);
        loadPage(32'hB000, 32'hC000, 204, 3);
        col_rd_en = 1'b1;
        pulseStart(32'hA000, 32'd7);
        applyStimulus(200, to);
        checks++; if (to !== 1'b0 || obsRows.size() !== 7 || srcQ.size() !== 0) begin
            errors++; $display("[TB] FAIL rescan_end: timeout=%0b rows=%0d left=%0d, want 0 7 0", to, obsRows.size(), srcQ.size()); end
        checks++; if (obsCmds.size() !== 1 || (obsCmds.size() > 0 && obsCmds[0] !== 32'hB000)) begin
            errors++; $display("[TB] FAIL rescan_cmd: count=%0d, expected one command to B000", obsCmds.size()); end
        for (int i = 0; i < 7; i++) begin
            gotRow = (i < obsRows.size()) ? obsRows[i] : 'x;
            checks++; if (gotRow !== makeRow(200 + i)) begin
                errors++; $display("[TB] FAIL rescan_row%0d: got %h expected %h", i, gotRow, makeRow(200 + i)); end
        end
    endtask

    task automatic test_lane_split();
        logic [47:0] words2 [2];
        int idx;
        words2[0] = {16'h0000, 32'h0000_0060};
        words2[1] = 48'hAAAA_BBBB_CCCC;
        readPageAddr2 = 32'h50;
        target2       = 32'h50;
        recordNum2    = 32'd1;
        dataIn2       = words2[0];
        dataValid2    = 1'b1;
        idx = 0;
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int c = 0; c < 20 && idx < 2; c++) begin
            @(negedge clk);
            if (dataRd2) begin
                @(posedge clk);
                #1;
                idx++;
                if (idx < 2) dataIn2 = words2[idx];
                else dataValid2 = 1'b0;
            end
        end
        @(negedge clk);
        checks++; if (idx !== 2 || colEmpty2 !== 1'b0) begin
            errors++; $display("[TB] FAIL lane_push: words popped=%0d empty=%0b, want 2 0", idx, colEmpty2); end
        colRdEn2 = 1'b1;
        @(negedge clk);
        colRdEn2 = 1'b0;
        checks++; if (colDout2[15:0] !== 16'hCCCC) begin
            errors++; $display("[TB] FAIL lane0: got %h expected cccc", colDout2[15:0]); end
        checks++; if (colDout2[31:16] !== 16'hBBBB) begin
            errors++; $display("[TB] FAIL lane1: got %h expected bbbb", colDout2[31:16]); end
        checks++; if (colDout2[47:32] !== 16'hAAAA) begin
            errors++; $display("[TB] FAIL lane2: got %h expected aaaa", colDout2[47:32]); end
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        target_page_addr = '0;
        record_num = '0;
        col_rd_en = 1'b0;
        start2 = 1'b0;
        target2 = '0;
        recordNum2 = '0;
        readPageAddr2 = '0;
        dataIn2 = '0;
        dataValid2 = 1'b0;
        colRdEn2 = 1'b0;
        refreshSource();
        test_reset();
        test_zero_records();
        test_full_scan();
        test_fifo_full();
        test_page_wait();
        test_reset_mid_scan();
        test_lane_split();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
